// File: rtl/pixel_write_feeder.sv
// Pixel write feeder: buffers captured pixels with their framebuffer address and presents each as a write held SLOT_CYCLES clocks.
// Latency: a pixel driven after edge N is stored at edge N+1 and reaches the write port at edge N+2 (idle, empty FIFO); queued writes run back-to-back.
// Backpressure: none upstream; a pixel meeting a full FIFO is dropped (sticky OwOverflow). Define PIXEL_WRITE_FEEDER_DROPCOUNT_EN for the drop counter.
module pixel_write_feeder #(
    parameter int          SLOT_CYCLES = 5,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [16:0] BASE_ADDR   = 17'h0,
    parameter int          FRAME_WORDS = 38400
) (
    input  logic        IwClk,
    input  logic        IwRstn,
    input  logic [15:0] IbPixel,
    input  logic        IwPixelValid,
    input  logic        IwFrameStart,
    input  logic        IwClearOverflow,
    output logic [16:0] ObWriteAddress,
    output logic [15:0] ObWriteData,
    output logic        OwWrite,
    output logic        OwOverflow,
    output logic [15:0] ObDropCount
);
    localparam int                PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                HOLD_W    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [16:0]       LAST_ADDR = BASE_ADDR + 17'(FRAME_WORDS - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(SLOT_CYCLES - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state, stateNxt;
    logic [HOLD_W-1:0] holdCnt, holdNxt;
    logic [16:0]       addrReg, addrNxt;
    logic [15:0]       dataReg, dataNxt;
    logic              writeReg, writeNxt;
    logic [16:0]       nextAddr, pixAddr;
    logic [32:0]       fifoMem [FIFO_DEPTH];
    logic [32:0]       fifoHead;
    logic [PTR_W:0]    wrPtr, rdPtr;
    logic              fifoEmpty, fifoFull, pop, push, drop;
    logic              overflow;

    // Address advances on every valid pixel, dropped or not, so frame geometry survives overflow.
    assign pixAddr = IwFrameStart ? BASE_ADDR : nextAddr;

    always_ff @(posedge IwClk or negedge IwRstn) begin
        if (!IwRstn)
            nextAddr <= BASE_ADDR;
        else if (IwPixelValid)
            nextAddr <= (pixAddr == LAST_ADDR) ? BASE_ADDR : pixAddr + 17'd1;
    end

    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[PTR_W] != rdPtr[PTR_W]) && (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
    assign fifoHead  = fifoMem[rdPtr[PTR_W-1:0]];
    assign push      = IwPixelValid && (!fifoFull || pop);
    assign drop      = IwPixelValid && fifoFull && !pop;

    always_ff @(posedge IwClk) begin
        if (push)
            fifoMem[wrPtr[PTR_W-1:0]] <= {pixAddr, IbPixel};
    end

    always_ff @(posedge IwClk or negedge IwRstn) begin
        if (!IwRstn) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push)
                wrPtr <= wrPtr + (PTR_W+1)'(1);
            if (pop)
                rdPtr <= rdPtr + (PTR_W+1)'(1);
        end
    end

    always_comb begin
        stateNxt = state;
        holdNxt  = holdCnt;
        addrNxt  = addrReg;
        dataNxt  = dataReg;
        writeNxt = writeReg;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                writeNxt = 1'b0;
                if (!fifoEmpty) begin
                    pop      = 1'b1;
                    stateNxt = HOLD;
                end
            end
            HOLD: begin
                if (holdCnt != '0)
                    holdNxt = holdCnt - HOLD_W'(1);
                else if (!fifoEmpty)
                    pop = 1'b1;
                else begin
                    writeNxt = 1'b0;
                    stateNxt = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase
        // A pop always opens a fresh full-length slot, whether from IDLE or back-to-back.
        if (pop) begin
            {addrNxt, dataNxt} = fifoHead;
            writeNxt           = 1'b1;
            holdNxt            = HOLD_INIT;
        end
    end

    always_ff @(posedge IwClk or negedge IwRstn) begin
        if (!IwRstn) begin
            state    <= IDLE;
            holdCnt  <= '0;
            addrReg  <= '0;
            dataReg  <= '0;
            writeReg <= 1'b0;
        end else begin
            state    <= stateNxt;
            holdCnt  <= holdNxt;
            addrReg  <= addrNxt;
            dataReg  <= dataNxt;
            writeReg <= writeNxt;
        end
    end

    // A clear coinciding with a fresh drop must leave the flag set.
    always_ff @(posedge IwClk or negedge IwRstn) begin
        if (!IwRstn)
            overflow <= 1'b0;
        else if (IwClearOverflow)
            overflow <= drop;
        else if (drop)
            overflow <= 1'b1;
    end

`ifdef PIXEL_WRITE_FEEDER_DROPCOUNT_EN
    logic [15:0] dropCnt;

    always_ff @(posedge IwClk or negedge IwRstn) begin
        if (!IwRstn)
            dropCnt <= '0;
        else if (IwClearOverflow)
            dropCnt <= {15'd0, drop};
        else if (drop && dropCnt != 16'hFFFF)
            dropCnt <= dropCnt + 16'd1;
    end

    assign ObDropCount = dropCnt;
`else
    assign ObDropCount = '0;
`endif

    assign ObWriteAddress = addrReg;
    assign ObWriteData    = dataReg;
    assign OwWrite        = writeReg;
    assign OwOverflow     = overflow;
endmodule

// File: tb/tb_pixel_write_feeder.sv
// Bench for pixel_write_feeder: scoreboard of expected writes plus a sampled controller model.
module tb_pixel_write_feeder;
    localparam int          SLOT = 5;
    localparam int          DEPTH = 8;
    localparam logic [16:0] BASE = 17'h01F0;
    localparam int          FW = 4;
`ifdef PIXEL_WRITE_FEEDER_DROPCOUNT_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    typedef struct packed {
        logic [16:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        IwClk = 1'b0;
    logic        IwRstn = 1'b0;
    logic [15:0] IbPixel = '0;
    logic        IwPixelValid = 1'b0;
    logic        IwFrameStart = 1'b0;
    logic        IwClearOverflow = 1'b0;
    logic [16:0] ObWriteAddress;
    logic [15:0] ObWriteData;
    logic        OwWrite;
    logic        OwOverflow;
    logic [15:0] ObDropCount;

    int  nChecks = 0;
    int  nFails = 0;
    wr_t expQ[$];
    logic [16:0] tbNext = BASE;

    always #5 IwClk = ~IwClk;

    pixel_write_feeder #(
        .SLOT_CYCLES(SLOT), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE), .FRAME_WORDS(FW)
    ) dut (
        .IwClk(IwClk), .IwRstn(IwRstn), .IbPixel(IbPixel), .IwPixelValid(IwPixelValid),
        .IwFrameStart(IwFrameStart), .IwClearOverflow(IwClearOverflow),
        .ObWriteAddress(ObWriteAddress), .ObWriteData(ObWriteData), .OwWrite(OwWrite),
        .OwOverflow(OwOverflow), .ObDropCount(ObDropCount)
    );

    // Scoreboard monitor: each write occupies SLOT consecutive samples; the first is matched to the queue.
    int  slotPos = 0;
    wr_t curWr, monExp;
    always @(negedge IwClk) begin
        if (!IwRstn) begin
            slotPos = 0;
        end else if (OwWrite === 1'b1) begin
            nChecks++;
            if (slotPos == 0) begin
                if (expQ.size() == 0) begin
                    nFails++;
                    $display("FAIL unexpected_write: got addr=%h data=%h, no write expected", ObWriteAddress, ObWriteData);
                end else begin
                    monExp = expQ.pop_front();
                    if ({ObWriteAddress, ObWriteData} !== monExp) begin
                        nFails++;
                        $display("FAIL write_value: got addr=%h data=%h, need addr=%h data=%h",
                                 ObWriteAddress, ObWriteData, monExp.addr, monExp.data);
                    end
                end
                curWr = {ObWriteAddress, ObWriteData};
            end else if ({ObWriteAddress, ObWriteData} !== curWr) begin
                nFails++;
                $display("FAIL write_stable: got addr=%h data=%h mid-slot, need addr=%h data=%h",
                         ObWriteAddress, ObWriteData, curWr.addr, curWr.data);
            end
            slotPos = (slotPos + 1) % SLOT;
        end else if (slotPos != 0) begin
            nChecks++;
            nFails++;
            $display("FAIL write_length: strobe dropped after %0d cycles, need %0d", slotPos, SLOT);
            slotPos = 0;
        end
    end

    // Controller model: latches whatever is on the port once every SLOT cycles at a chosen phase.
    bit  ctlOn = 1'b0;
    int  ctlPhase = 0;
    int  ctlCnt = 0;
    wr_t ctlQ[$];
    always @(negedge IwClk) begin
        if (ctlOn) begin
            if (ctlCnt == ctlPhase && OwWrite === 1'b1)
                ctlQ.push_back({ObWriteAddress, ObWriteData});
            ctlCnt = (ctlCnt + 1) % SLOT;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge IwClk);
        #1;
    endtask

    function automatic logic [16:0] modelAddr(input bit fs);
        logic [16:0] a;
        a = fs ? BASE : tbNext;
        tbNext = (a == BASE + 17'(FW - 1)) ? BASE : a + 17'd1;
        return a;
    endfunction

    task automatic sendPixel(input logic [15:0] d, input bit fs, input bit clr, input bit drop,
                             input logic [16:0] ea);
        wr_t w;
        w.addr = ea;
        w.data = d;
        if (!drop)
            expQ.push_back(w);
        IbPixel = d;
        IwPixelValid = 1'b1;
        IwFrameStart = fs;
        IwClearOverflow = clr;
        tick(1);
        IwPixelValid = 1'b0;
        IwFrameStart = 1'b0;
        IwClearOverflow = 1'b0;
    endtask

    task automatic waitIdle(input int maxCyc, output bit ok);
        int n;
        n = 0;
        while ((OwWrite !== 1'b0 || expQ.size() != 0) && n < maxCyc) begin
            tick(1);
            n++;
        end
        ok = (OwWrite === 1'b0 && expQ.size() == 0);
        tick(2);
    endtask

    task automatic resetDut();
        IwRstn = 1'b0;
        tick(2);
        expQ.delete();
        tbNext = BASE;
        IwRstn = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        IwRstn = 1'b0;
        tick(2);
        nChecks++; if (OwWrite !== 1'b0)        begin nFails++; $display("FAIL reset_write: got %b, need 0", OwWrite); end
        nChecks++; if (ObWriteAddress !== 17'h0) begin nFails++; $display("FAIL reset_addr: got %h, need 0", ObWriteAddress); end
        nChecks++; if (ObWriteData !== 16'h0)    begin nFails++; $display("FAIL reset_data: got %h, need 0", ObWriteData); end
        nChecks++; if (OwOverflow !== 1'b0)      begin nFails++; $display("FAIL reset_overflow: got %b, need 0", OwOverflow); end
        nChecks++; if (ObDropCount !== 16'h0)    begin nFails++; $display("FAIL reset_dropcount: got %h, need 0", ObDropCount); end
        IwRstn = 1'b1;
        tbNext = BASE;
        tick(2);
    endtask

    task automatic test_single();
        int hi;
        bit ok;
        sendPixel(16'hABCD, 1'b1, 1'b0, 1'b0, BASE);
        nChecks++; if (OwWrite !== 1'b0) begin nFails++; $display("FAIL single_early: strobe %b one edge after capture, need 0", OwWrite); end
        tick(1);
        nChecks++;
        if ({OwWrite, ObWriteAddress, ObWriteData} !== {1'b1, BASE, 16'hABCD}) begin
            nFails++;
            $display("FAIL single_first: got wr=%b addr=%h data=%h, need wr=1 addr=%h data=abcd",
                     OwWrite, ObWriteAddress, ObWriteData, BASE);
        end
        hi = 0;
        while (OwWrite === 1'b1 && hi < 20) begin
            hi++;
            tick(1);
        end
        nChecks++; if (hi !== SLOT) begin nFails++; $display("FAIL single_hold: strobe held %0d clocks, need %0d", hi, SLOT); end
        waitIdle(40, ok);
        nChecks++; if (ok !== 1'b1) begin nFails++; $display("FAIL single_drain: %0d writes pending, need 0", expQ.size()); end
    endtask

    task automatic test_back_to_back();
        int hi;
        bit ok;
        sendPixel(16'h1111, 1'b1, 1'b0, 1'b0, BASE);
        sendPixel(16'h2222, 1'b0, 1'b0, 1'b0, BASE + 17'd1);
        sendPixel(16'h3333, 1'b0, 1'b0, 1'b0, BASE + 17'd2);
        // The first write began one edge before the third pixel was taken, so one strobe clock is already past.
        hi = 0;
        while (OwWrite === 1'b1 && hi < 40) begin
            hi++;
            tick(1);
        end
        nChecks++; if (hi !== 3 * SLOT - 1) begin nFails++; $display("FAIL b2b_run: continuous strobe %0d clocks, need %0d", hi, 3 * SLOT - 1); end
        waitIdle(40, ok);
        nChecks++; if (ok !== 1'b1) begin nFails++; $display("FAIL b2b_drain: %0d writes pending, need 0", expQ.size()); end
    endtask

    task automatic test_addr_wrap();
        int  offs[6] = '{0, 1, 2, 3, 0, 1};
        bit  ok;
        resetDut();
        for (int i = 0; i < 6; i++)
            sendPixel(16'hA000 + 16'(i), 1'b0, 1'b0, 1'b0, BASE + 17'(offs[i]));
        IwFrameStart = 1'b1;
        tick(1);
        IwFrameStart = 1'b0;
        sendPixel(16'hA006, 1'b0, 1'b0, 1'b0, BASE + 17'd2);
        waitIdle(80, ok);
        nChecks++; if (ok !== 1'b1) begin nFails++; $display("FAIL wrap_drain: %0d writes pending, need 0", expQ.size()); end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [15:0] expDc;
        // Output slot plus pops at the 2nd, 7th and 12th edges absorb 11 of 14 pixels: 10, 12 and 13 are lost.
        for (int i = 0; i < 14; i++)
            sendPixel(16'hC000 + 16'(i), i == 0, 1'b0, (i == 10 || i == 12 || i == 13), modelAddr(i == 0));
        expDc = DC_EN ? 16'd3 : 16'd0;
        nChecks++; if (OwOverflow !== 1'b1)  begin nFails++; $display("FAIL ovf_set: got %b, need 1", OwOverflow); end
        nChecks++; if (ObDropCount !== expDc) begin nFails++; $display("FAIL ovf_count: got %0d, need %0d", ObDropCount, expDc); end
        sendPixel(16'hC00E, 1'b0, 1'b1, 1'b1, modelAddr(1'b0));
        expDc = DC_EN ? 16'd1 : 16'd0;
        nChecks++; if (OwOverflow !== 1'b1)  begin nFails++; $display("FAIL ovf_clear_drop: got %b, need 1", OwOverflow); end
        nChecks++; if (ObDropCount !== expDc) begin nFails++; $display("FAIL ovf_clear_count: got %0d, need %0d", ObDropCount, expDc); end
        waitIdle(200, ok);
        sendPixel(16'hC0FF, 1'b0, 1'b0, 1'b0, modelAddr(1'b0));
        waitIdle(40, ok);
        nChecks++; if (ok !== 1'b1) begin nFails++; $display("FAIL ovf_drain: %0d writes pending, need 0", expQ.size()); end
        nChecks++; if (OwOverflow !== 1'b1) begin nFails++; $display("FAIL ovf_sticky: got %b, need 1", OwOverflow); end
        IwClearOverflow = 1'b1;
        tick(1);
        IwClearOverflow = 1'b0;
        nChecks++; if (OwOverflow !== 1'b0)   begin nFails++; $display("FAIL ovf_cleared: got %b, need 0", OwOverflow); end
        nChecks++; if (ObDropCount !== 16'h0) begin nFails++; $display("FAIL ovf_count_cleared: got %0d, need 0", ObDropCount); end
    endtask

    task automatic test_reset_mid_hold();
        int hi;
        bit ok;
        sendPixel(16'h5A5A, 1'b1, 1'b0, 1'b0, modelAddr(1'b1));
        sendPixel(16'h6B6B, 1'b0, 1'b0, 1'b0, modelAddr(1'b0));
        tick(1);
        nChecks++; if (OwWrite !== 1'b1) begin nFails++; $display("FAIL midrst_pre: got %b, need 1", OwWrite); end
        #2;
        IwRstn = 1'b0;
        #1;
        nChecks++; if (OwWrite !== 1'b0) begin nFails++; $display("FAIL midrst_async: strobe %b under reset, need 0", OwWrite); end
        tick(2);
        expQ.delete();
        IwRstn = 1'b1;
        hi = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (OwWrite === 1'b1) hi++;
        end
        nChecks++; if (hi !== 0) begin nFails++; $display("FAIL midrst_stale: %0d strobe clocks after reset, need 0", hi); end
        sendPixel(16'h7E7E, 1'b1, 1'b0, 1'b0, modelAddr(1'b1));
        waitIdle(40, ok);
        nChecks++; if (ok !== 1'b1) begin nFails++; $display("FAIL midrst_drain: %0d writes pending, need 0", expQ.size()); end
    endtask

    task automatic test_random_rate();
        wr_t exp6[$];
        wr_t w;
        bit  ok;
        ctlPhase = $urandom_range(0, SLOT - 1);
        ctlCnt = 0;
        ctlQ.delete();
        ctlOn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            w.data = 16'($urandom);
            w.addr = modelAddr(i == 0);
            exp6.push_back(w);
            sendPixel(w.data, i == 0, 1'b0, 1'b0, w.addr);
            tick($urandom_range(SLOT - 1, SLOT + 2));
        end
        waitIdle(300, ok);
        tick(SLOT);
        ctlOn = 1'b0;
        nChecks++; if (ok !== 1'b1) begin nFails++; $display("FAIL rand_drain: %0d writes pending, need 0", expQ.size()); end
        nChecks++; if (ctlQ.size() !== exp6.size()) begin nFails++; $display("FAIL rand_count: controller latched %0d writes, need %0d", ctlQ.size(), exp6.size()); end
        for (int i = 0; i < exp6.size() && i < ctlQ.size(); i++) begin
            nChecks++;
            if (ctlQ[i] !== exp6[i]) begin
                nFails++;
                $display("FAIL rand_latch[%0d]: got addr=%h data=%h, need addr=%h data=%h",
                         i, ctlQ[i].addr, ctlQ[i].data, exp6[i].addr, exp6[i].data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_addr_wrap();
        test_overflow();
        test_reset_mid_hold();
        test_random_rate();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
